seq_multiplier_8bit: RTL and testbench



---
 rtl/seq_multiplier_8bit_pkg.sv | 20 ++
 rtl/seq_multiplier_8bit_if.sv | 41 ++++
 rtl/seq_multiplier_8bit_adder.sv | 31 +++
 rtl/seq_multiplier_8bit.sv | 125 ++++++++++++
 tb/tb_seq_multiplier_8bit.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/seq_multiplier_8bit_pkg.sv
// ---------------------------------------------------------------------------
// seq_multiplier_8bit_pkg
// Shared constants for the sequential multiplier: operand width, iteration
// counter width, product width and the multiplier FSM state encoding.
// Optional feature macro used by the files that import this package:
//   MUL_HIGH_NZ_FLAG_EN - adds the high_nz result flag.
// ---------------------------------------------------------------------------
package seq_multiplier_8bit_pkg;

    localparam int MUL_WIDTH = 8;
    localparam int MUL_CNT_W = 3;
    localparam int PROD_W    = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_multiplier_8bit_if.sv
// ---------------------------------------------------------------------------
// seq_multiplier_8bit_if
// start/busy/done handshake and operand/result bus of the multiplier.
//   start   : request a multiply (master -> slave)
//   num_1   : multiplicand        (master -> slave)
//   num_2   : multiplier          (master -> slave)
//   busy    : multiplier not idle (slave -> master)
//   done    : one-cycle completion pulse (slave -> master)
//   product : 16-bit result       (slave -> master)
//   high_nz : product[15:8] != 0, only with MUL_HIGH_NZ_FLAG_EN defined
// ---------------------------------------------------------------------------
interface seq_multiplier_8bit_if;
    import seq_multiplier_8bit_pkg::*;

    logic                 start;
    logic [MUL_WIDTH-1:0] num_1;
    logic [MUL_WIDTH-1:0] num_2;
    logic                 busy;
    logic                 done;
    logic [PROD_W-1:0]    product;
`ifdef MUL_HIGH_NZ_FLAG_EN
    logic                 high_nz;
`endif

    modport master (
        output start, num_1, num_2,
`ifdef MUL_HIGH_NZ_FLAG_EN
        input  high_nz,
`endif
        input  busy, done, product
    );

    modport slave (
        input  start, num_1, num_2,
`ifdef MUL_HIGH_NZ_FLAG_EN
        output high_nz,
`endif
        output busy, done, product
    );

endinterface

// File: rtl/seq_multiplier_8bit_adder.sv
// ---------------------------------------------------------------------------
// Adder_8bit
// 8-bit ripple-carry adder used as the multiplier's per-iteration adder.
//   num_1, num_2 : addends
//   c            : carry in
//   sum          : 8-bit sum
//   carry        : carry out
// ---------------------------------------------------------------------------
module Adder_8bit (
    input  logic [7:0] num_1,
    input  logic [7:0] num_2,
    input  logic       c,
    output logic [7:0] sum,
    output logic       carry
);

    logic [8:0] cy;

    always_comb begin
        cy    = '0;
        sum   = '0;
        cy[0] = c;
        for (int i = 0; i < 8; i++) begin
            sum[i]  = num_1[i] ^ num_2[i] ^ cy[i];
            cy[i+1] = (num_1[i] & num_2[i]) | (cy[i] & (num_1[i] ^ num_2[i]));
        end
    end

    assign carry = cy[8];

endmodule

// File: rtl/seq_multiplier_8bit.sv
// ---------------------------------------------------------------------------
// seq_multiplier_8bit
// Shift-and-add 8x8 unsigned multiplier: one add per cycle through
// Adder_8bit, 8 iterations, 16-bit product.
//   clk    : clock, rising edge
//   rst    : synchronous active-high reset
//   mul_if : slave side of the start/busy/done handshake and operand bus
// Optional feature macro: MUL_HIGH_NZ_FLAG_EN (adds mul_if.high_nz).
// ---------------------------------------------------------------------------
module seq_multiplier_8bit
    import seq_multiplier_8bit_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH,
    parameter int CNT_W = MUL_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    seq_multiplier_8bit_if.slave mul_if
);

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    mcand_q, mcand_d;
    logic [WIDTH-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0]    q_q, q_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2*WIDTH-1:0]  product_q, product_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
`ifdef MUL_HIGH_NZ_FLAG_EN
    logic                high_nz_q, high_nz_d;
`endif

    logic [WIDTH-1:0]    addend;
    logic [WIDTH-1:0]    add_sum;
    logic                add_carry;

    assign addend = q_q[0] ? mcand_q : '0;

    Adder_8bit u_adder (
        .num_1 (acc_q),
        .num_2 (addend),
        .c     (1'b0),
        .sum   (add_sum),
        .carry (add_carry)
    );

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        q_d       = q_q;
        cnt_d     = cnt_q;
        product_d = product_q;
`ifdef MUL_HIGH_NZ_FLAG_EN
        high_nz_d = high_nz_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (mul_if.start) begin
                    mcand_d = mul_if.num_1;
                    q_d     = mul_if.num_2;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // {carry,sum,q} >> 1: the carry-out lands in acc's MSB and the
                // sum LSB shifts into q as the next finished product bit.
                acc_d = {add_carry, add_sum[WIDTH-1:1]};
                q_d   = {add_sum[0], q_q[WIDTH-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == {CNT_W{1'b1}}) begin
                    product_d = {acc_d, q_d};
`ifdef MUL_HIGH_NZ_FLAG_EN
                    high_nz_d = (acc_d != '0);
`endif
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // Handshake outputs are registered from the next state so they line
        // up with the state they describe.
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            mcand_q   <= '0;
            acc_q     <= '0;
            q_q       <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef MUL_HIGH_NZ_FLAG_EN
            high_nz_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            acc_q     <= acc_d;
            q_q       <= q_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef MUL_HIGH_NZ_FLAG_EN
            high_nz_q <= high_nz_d;
`endif
        end
    end

    assign mul_if.busy    = busy_q;
    assign mul_if.done    = done_q;
    assign mul_if.product = product_q;
`ifdef MUL_HIGH_NZ_FLAG_EN
    assign mul_if.high_nz = high_nz_q;
`endif

endmodule

// File: tb/tb_seq_multiplier_8bit.sv
// ---------------------------------------------------------------------------
// tb_seq_multiplier_8bit
// Directed bench for seq_multiplier_8bit with hand-computed products.
// Inputs change and outputs are sampled 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_seq_multiplier_8bit;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    seq_multiplier_8bit_if mif ();

    seq_multiplier_8bit dut (
        .clk    (clk),
        .rst    (rst),
        .mul_if (mif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Single start pulse, then wait (bounded) for done and check the result.
    task automatic run_mul(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [15:0] exp);
        int lat;
        mif.num_1 = a;
        mif.num_2 = b;
        mif.start = 1'b1;
        step();
        mif.start = 1'b0;
        mif.num_1 = ~a;
        mif.num_2 = ~b;
        check({tag, "_busy_after_accept"}, 32'(mif.busy), 32'd1);
        lat = 0;
        while (!mif.done && lat < 20) begin
            check({tag, "_busy_while_run"}, 32'(mif.busy), 32'd1);
            step();
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'd8);
        check({tag, "_product"}, 32'(mif.product), 32'(exp));
`ifdef MUL_HIGH_NZ_FLAG_EN
        check({tag, "_high_nz"}, 32'(mif.high_nz), 32'(exp[15:8] != 8'h00));
`endif
        step();
        check({tag, "_done_one_cycle"}, 32'(mif.done), 32'd0);
        check({tag, "_busy_dropped"}, 32'(mif.busy), 32'd0);
        check({tag, "_product_held"}, 32'(mif.product), 32'(exp));
    endtask

    initial begin
        int ndone;
        int t_first;
        int t_second;
        logic [15:0] p_first;
        logic [15:0] p_second;

        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        mif.start = 1'b0;
        mif.num_1 = 8'h00;
        mif.num_2 = 8'h00;
        step();
        step();
        check("reset_busy", 32'(mif.busy), 32'd0);
        check("reset_done", 32'(mif.done), 32'd0);
        check("reset_product", 32'(mif.product), 32'd0);
`ifdef MUL_HIGH_NZ_FLAG_EN
        check("reset_high_nz", 32'(mif.high_nz), 32'd0);
`endif
        rst = 1'b0;
        step();

        run_mul("m13x11", 8'd13, 8'd11, 16'h008F);
        run_mul("mffxff", 8'hFF, 8'hFF, 16'hFE01);
        run_mul("m00xa5", 8'h00, 8'hA5, 16'h0000);
        run_mul("m5ax00", 8'h5A, 8'h00, 16'h0000);

        // 7*6 with 9*9 re-pulsed at RUN cycles 2 and 5 and during DONE.
        mif.num_1 = 8'd7;
        mif.num_2 = 8'd6;
        mif.start = 1'b1;
        step();
        ndone = 0;
        for (int c = 1; c <= 20; c++) begin
            mif.num_1 = 8'd9;
            mif.num_2 = 8'd9;
            mif.start = (c == 2 || c == 5 || c == 9);
            step();
            if (mif.done) begin
                ndone++;
                check("ign_product", 32'(mif.product), 32'h002A);
            end
        end
        mif.start = 1'b0;
        check("ign_done_count", 32'(ndone), 32'd1);
        check("ign_busy_idle", 32'(mif.busy), 32'd0);
        check("ign_product_held", 32'(mif.product), 32'h002A);
        run_mul("m9x9", 8'd9, 8'd9, 16'h0051);

        // Reset at the 4th RUN edge of 200*3.
        mif.num_1 = 8'd200;
        mif.num_2 = 8'd3;
        mif.start = 1'b1;
        step();
        mif.start = 1'b0;
        for (int c = 1; c <= 3; c++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_mid_busy", 32'(mif.busy), 32'd0);
        check("rst_mid_done", 32'(mif.done), 32'd0);
        check("rst_mid_product", 32'(mif.product), 32'd0);
        ndone = 0;
        for (int c = 0; c < 15; c++) begin
            step();
            if (mif.done) ndone++;
        end
        check("rst_mid_no_done", 32'(ndone), 32'd0);
        run_mul("m200x3", 8'd200, 8'd3, 16'h0258);

        // Back-to-back with start held high: 2*3 then 4*5.
        mif.num_1 = 8'd2;
        mif.num_2 = 8'd3;
        mif.start = 1'b1;
        step();
        mif.num_1 = 8'd4;
        mif.num_2 = 8'd5;
        t_first  = -1;
        t_second = -1;
        p_first  = 16'hDEAD;
        p_second = 16'hDEAD;
        for (int c = 1; c <= 30 && t_second < 0; c++) begin
            step();
            if (mif.done) begin
                if (t_first < 0) begin
                    t_first = c;
                    p_first = mif.product;
                end else begin
                    t_second  = c;
                    p_second  = mif.product;
                    mif.start = 1'b0;
                end
            end
        end
        mif.start = 1'b0;
        check("b2b_first_time", 32'(t_first), 32'd8);
        check("b2b_spacing", 32'(t_second - t_first), 32'd10);
        check("b2b_first_product", 32'(p_first), 32'h0006);
        check("b2b_second_product", 32'(p_second), 32'h0014);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
